// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 32-bit shift sequencer (SLL / SRL / SRA).
// One request at a time through valid/ready; the five binary-weighted stages
// (1, 2, 4, 8, 16) are applied one per clock to an internal working register.
// Shift amounts of 32 or more saturate to the fill value.
//
// Optional build macro: SHIFT_EARLY_EXIT_EN
//   undefined (default): every request takes the fixed 5-stage latency.
//   defined            : zero/saturating amounts go straight to DONE at
//                        acceptance; other amounts stop after the stage of
//                        the highest set bit of b[4:0].
// Results are bit-identical in both builds.
`timescale 1ns/1ps

module shift_seq_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t      state_q,  state_d;
    logic [31:0] work_q,   work_d;
    logic [4:0]  amt_q,    amt_d;
    logic [2:0]  stage_q,  stage_d;
    logic        dir_q,    dir_d;     // 1 = left, 0 = right
    logic        fill_q,   fill_d;    // vacated-bit value for right shifts
    logic [31:0] result_q, result_d;

    logic        sat_s;
    logic        acc_fill_s;
    logic        last_s;

    // One binary-weighted stage: shift w by 2^k toward the selected direction.
    function automatic logic [31:0] stage_shift(
        input logic [31:0] w,
        input logic [2:0]  k,
        input logic        left,
        input logic        fill
    );
        logic [31:0] r;
        case (k)
            3'd0:    r = left ? {w[30:0], 1'b0}     : {fill, w[31:1]};
            3'd1:    r = left ? {w[29:0], 2'b00}    : {{2{fill}}, w[31:2]};
            3'd2:    r = left ? {w[27:0], 4'h0}     : {{4{fill}}, w[31:4]};
            3'd3:    r = left ? {w[23:0], 8'h00}    : {{8{fill}}, w[31:8]};
            3'd4:    r = left ? {w[15:0], 16'h0000} : {{16{fill}}, w[31:16]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Outputs decoded from state or taken straight from registers.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

    // Next-state logic: acceptance, per-stage shifting and result handshake.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        amt_d      = amt_q;
        stage_d    = stage_q;
        dir_d      = dir_q;
        fill_d     = fill_q;
        result_d   = result_q;
        sat_s      = |b[31:5];
        acc_fill_s = (op == OP_SRA) & a[31];
        last_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dir_d   = (op == OP_SLL);
                    fill_d  = acc_fill_s;
                    // Saturated requests keep the pattern fixed: the fill word
                    // is invariant under every stage, so no shifting is needed.
                    work_d  = sat_s ? {32{acc_fill_s}} : a;
                    amt_d   = sat_s ? 5'd0 : b[4:0];
                    stage_d = 3'd0;
`ifdef SHIFT_EARLY_EXIT_EN
                    if (sat_s || (b[4:0] == 5'd0)) begin
                        state_d  = ST_DONE;
                        result_d = sat_s ? {32{acc_fill_s}} : a;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
`else
                    state_d = ST_SHIFT;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (amt_q[stage_q]) begin
                    work_d = stage_shift(work_q, stage_q, dir_q, fill_q);
                end else begin
                    work_d = work_q;
                end
`ifdef SHIFT_EARLY_EXIT_EN
                // Stop once no higher amount bit remains to be applied.
                last_s = (((amt_q >> stage_q) >> 3'd1) == 5'd0);
`else
                last_s = (stage_q == 3'd4);
`endif
                if (last_s) begin
                    state_d  = ST_DONE;
                    stage_d  = 3'd0;
                    result_d = work_d;
                end else begin
                    stage_d  = stage_q + 3'd1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                stage_d = 3'd0;
            end
        endcase
    end

    // State and datapath registers; async reset discards any in-flight request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            work_q   <= 32'd0;
            amt_q    <= 5'd0;
            stage_q  <= 3'd0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            stage_q  <= stage_d;
            dir_q    <= dir_d;
            fill_q   <= fill_d;
            result_q <= result_d;
        end
    end

endmodule
